sr_request_conditioner: RTL and testbench

SR_REQUEST_CONDITIONER -- requirements
Module: sr_request_conditioner

---
 rtl/sr_request_conditioner.sv | 108 ++++++++++
 tb/tb_sr_request_conditioner.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sr_request_conditioner.sv
// sr_request_conditioner
//   Conditions two raw, bouncy push-button requests into clean one-cycle
//   S/R pulses for a downstream SR latch, and tracks the latch state locally.
//   Each button is synchronized (2 flops), debounced, and only a rising
//   debounced level produces a request event. Simultaneous set and reset
//   events are dropped and counted as conflicts.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   set_btn      : raw asynchronous set request
//   reset_btn    : raw asynchronous reset request
//   S            : one-cycle set pulse (registered)
//   R            : one-cycle reset pulse (registered)
//   q_model      : expected downstream latch Q (registered)
//   conflict     : one-cycle flag, simultaneous set/reset events were dropped
//   conflict_cnt : saturating conflict event count
module sr_request_conditioner #(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_btn,
  input  logic       reset_btn,
  output logic       S,
  output logic       R,
  output logic       q_model,
  output logic       conflict,
  output logic [7:0] conflict_cnt
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  // channel 0 = set, channel 1 = reset
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    db_d;
  logic [CW-1:0] cnt [2];
  logic [1:0]    ev;
  logic          set_ev;
  logic          rst_ev;

  assign raw = {reset_btn, set_btn};

  // Synchronizer, debounce counters and edge-detect history
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_d   <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_d  <= db;
      for (int ch = 0; ch < 2; ch++) begin
        if (sync2[ch] == db[ch]) begin
          cnt[ch] <= '0;
        end else if (cnt[ch] == CNT_LAST) begin
          // DB_CYCLES-th consecutive differing edge: accept the new level
          db[ch]  <= sync2[ch];
          cnt[ch] <= '0;
        end else begin
          cnt[ch] <= cnt[ch] + CW'(1);
        end
      end
    end
  end

  // Only a debounced 0->1 transition is a request; db_d is cleared by
  // reset, so a button held through reset is seen as a fresh press.
  assign ev     = db & ~db_d;
  assign set_ev = ev[0];
  assign rst_ev = ev[1];

  // Pulse generation and latch model
  always_ff @(posedge clk) begin
    if (rst) begin
      S            <= 1'b0;
      R            <= 1'b0;
      q_model      <= 1'b0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      S        <= 1'b0;
      R        <= 1'b0;
      conflict <= 1'b0;
      if (set_ev && rst_ev) begin
        conflict <= 1'b1;
        if (conflict_cnt != 8'hFF) begin
          conflict_cnt <= conflict_cnt + 8'd1;
        end
      end else if (set_ev && !q_model) begin
        S       <= 1'b1;
        q_model <= 1'b1;
      end else if (rst_ev && q_model) begin
        R       <= 1'b1;
        q_model <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sr_request_conditioner.sv
// tb_sr_request_conditioner
//   Scoreboard bench for sr_request_conditioner (DB_CYCLES = 4). Each press
//   pushes the edge number, pulse kind {S,R,conflict} and resulting q_model
//   at which a pulse must appear; a monitor pops and compares on every pulse.
module tb_sr_request_conditioner;

  localparam int DB = 4;
  localparam int LAT = DB + 3; // drive after edge n -> sampled at n+1 -> pulse at n+1+DB+2

  logic       clk;
  logic       rst;
  logic       set_btn;
  logic       reset_btn;
  logic       S;
  logic       R;
  logic       q_model;
  logic       conflict;
  logic [7:0] conflict_cnt;

  sr_request_conditioner #(.DB_CYCLES(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .set_btn      (set_btn),
    .reset_btn    (reset_btn),
    .S            (S),
    .R            (R),
    .q_model      (q_model),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         edge_no;
    logic [2:0] kind;
    logic       q;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [2:0] K_S = 3'b100;
  localparam logic [2:0] K_R = 3'b010;
  localparam logic [2:0] K_C = 3'b001;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] kind, input logic q);
    exp_t x;
    x.edge_no = cyc + LAT;
    x.kind    = kind;
    x.q       = q;
    sb.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_out"}, {28'd0, S, R, q_model, conflict}, 32'd0);
    check_val({tag, "_cnt"}, conflict_cnt, 32'd0);
  endtask

  // Monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (S && R) check_val("s_r_both", {S, R}, 2'b00);
    if (S || R || conflict) begin
      if (sb.size() == 0) begin
        check_val("unexpected_pulse", {S, R, conflict}, 3'b000);
      end else begin
        e = sb.pop_front();
        check_val("pulse_edge", cyc, e.edge_no);
        check_val("pulse_kind", {S, R, conflict}, e.kind);
        check_val("pulse_q", q_model, e.q);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    step(3);
    check_all_zero("reset");
    rst = 1'b0;
    step(3);

    // Set press while q=0, held long: exactly one S pulse
    set_btn = 1'b1; push_exp(K_S, 1'b1);
    step(12); check_val("q_after_set", q_model, 1);
    step(10); check_val("q_held_set", q_model, 1);
    set_btn = 1'b0; step(10);

    // Reset press while q=1
    reset_btn = 1'b1; push_exp(K_R, 1'b0);
    step(14); check_val("q_after_reset", q_model, 0);
    reset_btn = 1'b0; step(10);

    // Second set press
    set_btn = 1'b1; push_exp(K_S, 1'b1);
    step(12); set_btn = 1'b0; step(10);

    // Set while q=1 is discarded
    set_btn = 1'b1; step(12);
    check_val("q_set_discard", q_model, 1);
    set_btn = 1'b0; step(10);

    reset_btn = 1'b1; push_exp(K_R, 1'b0);
    step(12); reset_btn = 1'b0; step(10);

    // Reset while q=0 is discarded
    reset_btn = 1'b1; step(12);
    check_val("q_reset_discard", q_model, 0);
    reset_btn = 1'b0; step(10);

    // Events on adjacent edges: S then R one cycle later
    set_btn = 1'b1; push_exp(K_S, 1'b1);
    step(1);
    reset_btn = 1'b1; push_exp(K_R, 1'b0);
    step(12); check_val("q_adjacent", q_model, 0);
    set_btn = 1'b0; reset_btn = 1'b0; step(10);

    // Short bounces never reach the debounced level
    for (int i = 0; i < 5; i++) begin
      set_btn = 1'b1; step(3);
      set_btn = 1'b0; step(3);
    end
    step(10);
    check_val("q_bounce", q_model, 0);

    // Single conflict
    set_btn = 1'b1; reset_btn = 1'b1; push_exp(K_C, 1'b0);
    step(12);
    check_val("conflict_cnt_1", conflict_cnt, 1);
    check_val("q_conflict", q_model, 0);
    set_btn = 1'b0; reset_btn = 1'b0; step(12);

    // Conflict counter saturation
    for (int i = 0; i < 300; i++) begin
      set_btn = 1'b1; reset_btn = 1'b1; push_exp(K_C, 1'b0);
      step(8);
      set_btn = 1'b0; reset_btn = 1'b0;
      step(10);
    end
    check_val("conflict_cnt_sat", conflict_cnt, 255);
    check_val("q_after_sat", q_model, 0);

    // Reset mid-debounce, button held through reset
    set_btn = 1'b1; step(2);
    rst = 1'b1; step(1);
    check_all_zero("mid_rst_a");
    step(1);
    check_all_zero("mid_rst_b");
    rst = 1'b0; push_exp(K_S, 1'b1);
    step(12);
    check_val("q_after_rst_release", q_model, 1);
    check_val("cnt_after_rst", conflict_cnt, 0);
    set_btn = 1'b0; step(10);

    // Reset landing on the would-be R pulse edge aborts it; held button
    // then re-triggers after release but q=0 so it is discarded.
    reset_btn = 1'b1; step(LAT - 1);
    rst = 1'b1; step(1);
    check_all_zero("rst_on_pulse");
    rst = 1'b0; step(14);
    check_val("q_rst_on_pulse", q_model, 0);
    reset_btn = 1'b0; step(10);

    check_val("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
